// File: rtl/mdu_pkg.sv
// mdu_pkg: shared op codes, FSM state encoding and sizing constants
// for the iterative multiply/divide unit and its write-back select logic.
package mdu_pkg;

    localparam int MDU_WIDTH = 16;
    localparam int MDU_ITER  = 16;

    localparam logic [1:0] OP_MULTU = 2'b00;
    localparam logic [1:0] OP_MULT  = 2'b01;
    localparam logic [1:0] OP_DIVU  = 2'b10;
    localparam logic [1:0] OP_DIV   = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } mdu_state_t;

endpackage

// File: rtl/mdu_addsub.sv
// mdu_addsub: W-bit combinational add/subtract with carry-out.
// Ports: a_i, b_i operands; sub_i selects a-b; sum_o result; cout_o carry
// (for subtract, cout_o=1 means no borrow, i.e. a_i >= b_i).
module mdu_addsub
    import mdu_pkg::*;
#(
    parameter int W = MDU_WIDTH + 1
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic         sub_i,
    output logic [W-1:0] sum_o,
    output logic         cout_o
);

    logic [W-1:0] b_x;
    logic [W:0]   res;

    assign b_x = sub_i ? ~b_i : b_i;
    assign res = {1'b0, a_i} + {1'b0, b_x} + {{W{1'b0}}, sub_i};
    assign {cout_o, sum_o} = res;

endmodule

// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative MULT/MULTU/DIV/DIVU, one bit per cycle, HI/LO out.
// Ports: clk, rst_n, start/op/a/b request; busy, done, hi, lo, div_by_zero.
module mult_div_unit
    import mdu_pkg::*;
#(
    parameter int WIDTH = MDU_WIDTH,
    parameter int ITER  = MDU_ITER
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_by_zero
);

    localparam int CW = $clog2(ITER);
    localparam logic [CW-1:0] LAST = CW'(ITER - 1);

    mdu_state_t state_q, state_d;

    logic [1:0]       op_q, op_d;
    logic             sa_q, sa_d;
    logic             sb_q, sb_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] mq_q, mq_d;
    logic [WIDTH-1:0] opnd_q, opnd_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             dbz_q, dbz_d;

    logic             in_signed, in_div;
    logic             run_div, run_signed;
    logic [WIDTH-1:0] a_mag, b_mag;

    logic [WIDTH:0]   as_a, as_b, as_s;
    logic             as_sub, as_co;

    logic [2*WIDTH-1:0] prod, prod_n;
    logic [WIDTH-1:0]   acc_n, mq_n;

    assign in_signed  = (op == OP_MULT) || (op == OP_DIV);
    assign in_div     = (op == OP_DIVU) || (op == OP_DIV);
    assign run_signed = (op_q == OP_MULT) || (op_q == OP_DIV);
    assign run_div    = (op_q == OP_DIVU) || (op_q == OP_DIV);

    assign a_mag = (in_signed && a[WIDTH-1]) ? -a : a;
    assign b_mag = (in_signed && b[WIDTH-1]) ? -b : b;

    // Multiply: {acc,mq} is the product shift register, opnd the multiplicand.
    // Divide: acc is the partial remainder, mq the dividend/quotient.
    always_comb begin
        as_b = {1'b0, opnd_q};
        if (run_div) begin
            as_a   = {acc_q, mq_q[WIDTH-1]};
            as_sub = 1'b1;
        end else begin
            as_a   = {1'b0, acc_q};
            as_sub = 1'b0;
        end
    end

    mdu_addsub #(
        .W(WIDTH + 1)
    ) u_addsub (
        .a_i   (as_a),
        .b_i   (as_b),
        .sub_i (as_sub),
        .sum_o (as_s),
        .cout_o(as_co)
    );

    assign prod   = {acc_q, mq_q};
    assign prod_n = -prod;
    assign acc_n  = -acc_q;
    assign mq_n   = -mq_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        acc_d   = acc_q;
        mq_d    = mq_q;
        opnd_d  = opnd_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        dbz_d   = dbz_q;
        unique case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (start) begin
                    state_d = S_RUN;
                    op_d    = op;
                    sa_d    = in_signed & a[WIDTH-1];
                    sb_d    = in_signed & b[WIDTH-1];
                    acc_d   = '0;
                    cnt_d   = '0;
                    dbz_d   = 1'b0;
                    if (in_div) begin
                        mq_d   = a_mag;
                        opnd_d = b_mag;
                    end else begin
                        mq_d   = b_mag;
                        opnd_d = a_mag;
                    end
                end
            end
            S_RUN: begin
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    state_d = S_FIX;
                end
                if (run_div) begin
                    if (as_co) begin
                        acc_d = as_s[WIDTH-1:0];
                        mq_d  = {mq_q[WIDTH-2:0], 1'b1};
                    end else begin
                        acc_d = {acc_q[WIDTH-2:0], mq_q[WIDTH-1]};
                        mq_d  = {mq_q[WIDTH-2:0], 1'b0};
                    end
                end else begin
                    if (mq_q[0]) begin
                        acc_d = as_s[WIDTH:1];
                        mq_d  = {as_s[0], mq_q[WIDTH-1:1]};
                    end else begin
                        acc_d = {1'b0, acc_q[WIDTH-1:1]};
                        mq_d  = {acc_q[0], mq_q[WIDTH-1:1]};
                    end
                end
            end
            S_FIX: begin
                state_d = S_DONE;
                if (!run_div) begin
                    if (sa_q ^ sb_q) begin
                        {hi_d, lo_d} = prod_n;
                    end else begin
                        {hi_d, lo_d} = prod;
                    end
                end else if (opnd_q == '0) begin
                    // With a zero divisor every trial succeeds, so the
                    // remainder register ends up holding |a| again.
                    dbz_d = 1'b1;
                    lo_d  = '1;
                    hi_d  = sa_q ? acc_n : acc_q;
                end else begin
                    lo_d = (sa_q ^ sb_q) ? mq_n : mq_q;
                    hi_d = sa_q ? acc_n : acc_q;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q   <= OP_MULTU;
            sa_q   <= 1'b0;
            sb_q   <= 1'b0;
            acc_q  <= '0;
            mq_q   <= '0;
            opnd_q <= '0;
            cnt_q  <= '0;
            hi_q   <= '0;
            lo_q   <= '0;
            dbz_q  <= 1'b0;
        end else begin
            op_q   <= op_d;
            sa_q   <= sa_d;
            sb_q   <= sb_d;
            acc_q  <= acc_d;
            mq_q   <= mq_d;
            opnd_q <= opnd_d;
            cnt_q  <= cnt_d;
            hi_q   <= hi_d;
            lo_q   <= lo_d;
            dbz_q  <= dbz_d;
        end
    end

    assign busy        = (state_q == S_RUN) || (state_q == S_FIX);
    assign done        = (state_q == S_DONE);
    assign hi          = hi_q;
    assign lo          = lo_q;
    assign div_by_zero = dbz_q;

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Iterative 16-bit multiply/divide unit for the MIPS datapath. It executes MULT, MULTU, DIV and DIVU one bit per cycle.
- It holds its result in HI/LO registers.
- hi/lo feed the 16-bit write-back select mux on the mfhi/mflo path.
- The unit is sequential, with a start/busy/done handshake to the pipeline stall logic.

Parameters:
- WIDTH, 16, operand and HI/LO width. Only 16 is verified.
- ITER, 16, iteration cycles. Must equal WIDTH.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- start  input  1  request a new operation. Sampled on the rising edge.
- op  input  2  operation: 00 MULTU, 01 MULT, 10 DIVU, 11 DIV
- a  input  16  multiplicand / dividend
- b  input  16  multiplier / divisor
- busy  output  1  operation in progress. New starts are ignored while high.
- done  output  1  one-cycle pulse. hi/lo are valid from this cycle.
- hi  output  16  product[31:16] or remainder
- lo  output  16  product[15:0] or quotient
- div_by_zero  output  1  set with done when a DIV or DIVU had b==0. Cleared on the next accepted start.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset values: state=IDLE, busy=0, done=0, hi=0, lo=0, div_by_zero=0, iteration counter=0. Reset applies immediately, regardless of clk.
- States: IDLE, RUN, FIX, DONE.
  - IDLE: start=1 -> RUN. On the same edge, latch op, |a| and |b| (magnitudes for the signed ops, raw values for the unsigned ops) and the operand signs. Clear the counter, the accumulator and div_by_zero.
  - RUN: one shift-add (multiply) or restoring shift-subtract (divide) step per edge, counter increments. After the edge with counter==15 -> FIX.
  - FIX: sign correction.
    - MULT: negate the 32-bit product if sign(a)^sign(b).
    - DIV: negate the quotient if sign(a)^sign(b); negate the remainder if sign(a).
    - Then -> DONE, loading hi/lo on this edge.
  - DONE: done=1 for exactly one cycle -> IDLE. start=1 in DONE is accepted exactly as in IDLE, so back-to-back operations incur no bubble.
- busy=1 in RUN and FIX only. done=1 in DONE only.
- Latency: if start is sampled at edge k, done is high in the cycle between edges k+17 and k+18. busy is high from edge k to edge k+17.
- start while busy: ignored. The running operation is not disturbed. Changes to a, b or op after the sampling edge have no effect.
- hi/lo update only on FIX->DONE. They hold their value at all other times, including across ignored starts.
- Arithmetic:
  - Multiply: 32-bit two's-complement product; hi=[31:16], lo=[15:0].
  - Divide: truncates toward zero; the remainder takes the sign of the dividend.
  - Internal datapath: 17-bit partial-remainder adder/subtractor.
- Divide by zero (b==0): the full latency still elapses. Result is lo=16'hFFFF, hi=a (the original, unnegated a), div_by_zero=1 with done. This applies to signed and unsigned.
- Signed overflow: 0x8000 / 0xFFFF gives lo=0x8000, hi=0x0000, div_by_zero=0.
- Reset mid-operation: all state and outputs return to reset values immediately. No done is produced for the aborted operation.
- No X propagation: an op value from the unused encoding space does not exist (2-bit fully decoded).

Decomposition:
- Shared package mdu_pkg holds:
  - op localparams OP_MULTU, OP_MULT, OP_DIVU, OP_DIV
  - state encoding S_IDLE, S_RUN, S_FIX, S_DONE
  - constants MDU_WIDTH=16 and MDU_ITER=16
- The write-back select logic also imports the op codes from mdu_pkg.
- One natural sub-module: mdu_addsub, a 17-bit combinational add/subtract with carry-out, shared between the multiply accumulate and divide trial-subtract steps.
- Control FSM and registers stay in mult_div_unit.

Test Plan:
- MULTU a=0xFFFF b=0xFFFF -> done exactly 18 cycles after the start edge; hi=0xFFFE, lo=0x0001; busy high for 17 cycles.
- MULT a=0xFFFD (-3) b=0x0007 -> hi=0xFFFF, lo=0xFFEB (-21). Then DIV a=0x8000 b=0xFFFF -> lo=0x8000, hi=0x0000, div_by_zero=0.
- DIV a=0xFFF9 (-7) b=0x0002 -> lo=0xFFFD (-3), hi=0xFFFF (-1). DIVU a=0x0064 b=0x0007 -> lo=0x000E, hi=0x0002.
- DIVU a=0x1234 b=0x0000 -> lo=0xFFFF, hi=0x1234, div_by_zero=1 with done. The next accepted MULTU clears div_by_zero on its start edge.
- Start MULTU 3*5, then pulse start with a=0x7777 b=0x7777 at cycle 5 and change a/b every cycle -> result hi=0x0000, lo=0x000F. Start with 2*2 asserted in the DONE cycle -> accepted; second done 18 cycles later with lo=0x0004.
- Assert rst_n=0 mid-cycle during RUN iteration 8 -> busy, done, hi, lo all 0 without waiting for a clock edge. Release reset -> no done appears within 20 cycles.
